vga_sync_rx: RTL and testbench

- Receive side of the 640x480 VGA timing interface.
- Consumes the active-low hsync/vsync and the de produced by the display timing generator (or an external source).
- Recovers per-pixel coordinates, measures line and frame periods, and declares lock once timing matches the expected 640x480 format for LOCK_FRAMES consecutive frames.
- Sits in front of capture/checker logic that needs sx/sy without access to the generator's counters.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_sync_rx_if.sv | 27 ++
 rtl/sync_edge_det.sv | 24 ++
 rtl/vga_sync_rx.sv | 180 ++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480 timing constants and the lock-state encoding for the VGA sync receiver.
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;

    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 525;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_sync_rx_if.sv
// Sync/DE inputs and recovered coordinate/status outputs of the VGA sync receiver.
interface vga_sync_rx_if #(
    parameter int CORDW = 10,
    parameter int MEASW = 12
);
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             pix_valid;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             frame_start;
    logic [MEASW-1:0] h_total;
    logic [MEASW-1:0] v_total;
    logic             locked;
    logic             err;

    modport master (
        output hsync, vsync, de,
        input  pix_valid, sx, sy, frame_start, h_total, v_total, locked, err
    );

    modport slave (
        input  hsync, vsync, de,
        output pix_valid, sx, sy, frame_start, h_total, v_total, locked, err
    );
endinterface

// File: rtl/sync_edge_det.sv
// Registers one timing input and flags its rising/falling transitions one cycle later.
module sync_edge_det (
    input  logic clk_pix,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic q_prev;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            q      <= 1'b0;
            q_prev <= 1'b0;
        end else begin
            q      <= d;
            q_prev <= q;
        end
    end

    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;
endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers sx/sy from hsync/vsync/de, measures line/frame periods, tracks lock.
//   state  | meaning
//   SEARCH | no frame boundary seen yet (after reset or line timeout)
//   CHECK  | counting consecutive good frames toward lock
//   LOCKED | timing matches the expected format
module vga_sync_rx #(
    parameter int CORDW       = 10,
    parameter int MEASW       = 12,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input logic          clk_pix,
    input logic          rst,
    vga_sync_rx_if.slave bus
);
    import vga_pkg::*;

    localparam int               GCW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [MEASW-1:0] MEAS_MAX = '1;
    localparam logic [CORDW-1:0] CORD_MAX = '1;
    localparam logic [MEASW-1:0] TIMEOUT  = MEASW'(2 * H_TOTAL);

    logic hs_q, hs_rise, hs_fall;
    logic vs_q, vs_rise, vs_fall;
    logic de_q, de_rise, de_fall;
    logic unused_sync;

    sync_edge_det u_hs (.clk_pix(clk_pix), .rst(rst), .d(bus.hsync), .q(hs_q), .rise(hs_rise), .fall(hs_fall));
    sync_edge_det u_vs (.clk_pix(clk_pix), .rst(rst), .d(bus.vsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall));
    sync_edge_det u_de (.clk_pix(clk_pix), .rst(rst), .d(bus.de),    .q(de_q), .rise(de_rise), .fall(de_fall));

    assign unused_sync = ^{hs_q, hs_rise, vs_q, vs_rise};

    logic [CORDW-1:0] sx_r, sy_r, sx_o, sy_o;
    logic [MEASW-1:0] hcnt, vcnt, run_cnt, h_total_r, v_total_r;
    logic             pix_valid_r, frame_start_r, err_r;
    logic             seen_line, frame_bad;

    logic [MEASW-1:0] h_meas, vcnt_nxt;
    logic [CORDW:0]   lines_now;
    logic             h_bad, w_bad, frame_good, timeout;

    assign h_meas    = (hcnt == MEAS_MAX) ? MEAS_MAX : hcnt + 1'b1;
    assign h_bad     = hs_fall && seen_line && (h_meas != MEASW'(H_TOTAL));
    assign w_bad     = de_fall && (run_cnt != MEASW'(H_ACTIVE));
    assign vcnt_nxt  = (hs_fall && (vcnt != MEAS_MAX)) ? vcnt + 1'b1 : vcnt;
    // A de_fall coinciding with vs_fall still closes a line of the ending frame.
    assign lines_now = {1'b0, sy_r} + {{CORDW{1'b0}}, de_fall};
    assign frame_good = !(frame_bad || h_bad || w_bad
                          || (vcnt_nxt != MEASW'(V_TOTAL))
                          || (lines_now != (CORDW+1)'(V_ACTIVE)));
    assign timeout   = (hcnt == TIMEOUT) && !hs_fall;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sx_r          <= '0;
            sy_r          <= '0;
            sx_o          <= '0;
            sy_o          <= '0;
            hcnt          <= '0;
            vcnt          <= '0;
            run_cnt       <= '0;
            h_total_r     <= '0;
            v_total_r     <= '0;
            pix_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            seen_line     <= 1'b0;
            frame_bad     <= 1'b0;
        end else begin
            pix_valid_r   <= de_q;
            frame_start_r <= vs_fall;

            if (de_q) begin
                sx_o <= sx_r;
                sy_o <= sy_r;
                sx_r <= sx_r + 1'b1;
            end else if (de_fall) begin
                sx_r <= '0;
            end

            if (vs_fall)
                sy_r <= '0;
            else if (de_fall && (sy_r != CORD_MAX))
                sy_r <= sy_r + 1'b1;

            if (de_rise)
                run_cnt <= MEASW'(1);
            else if (de_q && (run_cnt != MEAS_MAX))
                run_cnt <= run_cnt + 1'b1;

            if (hs_fall) begin
                h_total_r <= h_meas;
                hcnt      <= '0;
                seen_line <= 1'b1;
            end else if (hcnt != MEAS_MAX) begin
                hcnt <= hcnt + 1'b1;
            end

            if (vs_fall) begin
                v_total_r <= vcnt_nxt;
                vcnt      <= '0;
                frame_bad <= 1'b0;
            end else begin
                vcnt <= vcnt_nxt;
                if (h_bad || w_bad)
                    frame_bad <= 1'b1;
            end
        end
    end

    lock_state_t      state_q, state_d;
    logic [GCW-1:0]   good_cnt_q, good_cnt_d;
    logic [GCW:0]     good_inc;
    logic             err_d;

    assign good_inc = {1'b0, good_cnt_q} + 1'b1;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
            err_r      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            err_r      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        if (timeout) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
            err_d      = (state_q == LOCKED);
        end else if (vs_fall) begin
            case (state_q)
                SEARCH: begin
                    state_d    = CHECK;
                    good_cnt_d = '0;
                end
                CHECK: begin
                    if (!frame_good) begin
                        good_cnt_d = '0;
                    end else if (good_inc >= (GCW+1)'(LOCK_FRAMES)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_inc[GCW-1:0];
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_d    = CHECK;
                        good_cnt_d = '0;
                        err_d      = 1'b1;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.pix_valid   = pix_valid_r;
    assign bus.sx          = sx_o;
    assign bus.sy          = sy_o;
    assign bus.frame_start = frame_start_r;
    assign bus.h_total     = h_total_r;
    assign bus.v_total     = v_total_r;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.err         = err_r;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx using a scaled-down timing format (24x10 clocks/lines).
module tb_vga_sync_rx;
    localparam int HA = 16, HT = 24, HS0 = 18, HS1 = 21;
    localparam int VA = 6,  VT = 10, VS0 = 7,  VS1 = 9;

    logic clk_pix = 1'b0;
    logic rst;

    vga_sync_rx_if #(.CORDW(10), .MEASW(12)) bus ();

    vga_sync_rx #(
        .CORDW(10), .MEASW(12),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_pix(clk_pix),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_pix = ~clk_pix;

    int checks = 0, errors = 0, err_cnt = 0;
    int fr = 0, ln = 0, cl = 0;
    int p0 = -1, p1 = -1, p2 = -1;
    int short_f = -1, short_l = -1, wide_f = -1, wide_l = -1, hold_f = -1;

    always @(negedge clk_pix) if (bus.err === 1'b1) err_cnt++;

    typedef struct {
        int f; int l; int c;
        int v; int sx; int sy; int lk; int fs;
    } vec_t;
    vec_t vecs[12];

    function automatic int pkey(input int f, input int l, input int c);
        return (f * VT + l) * 100 + c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One pixel clock of the reference stream, with optional per-line anomalies.
    task automatic step();
        int len, dlen;
        logic h, v, d;
        len  = (fr == short_f && ln == short_l) ? HT - 1 : HT;
        dlen = (fr == wide_f && ln == wide_l) ? HA + 1 : HA;
        d = (ln < VA) && (cl < dlen);
        h = !((cl >= HS0) && (cl < HS1)) || (fr == hold_f && (ln == 1 || ln == 2));
        v = !((ln >= VS0) && (ln < VS1));
        @(posedge clk_pix); #1;
        bus.hsync = h; bus.vsync = v; bus.de = d;
        p2 = p1; p1 = p0; p0 = pkey(fr, ln, cl);
        cl++;
        if (cl >= len) begin
            cl = 0; ln++;
            if (ln >= VT) begin ln = 0; fr++; end
        end
    endtask

    // Advance until outputs reflect the inputs driven at (f,l,c).
    task automatic go_to(input int f, input int l, input int c);
        int n = 0;
        int key = pkey(f, l, c);
        while (p2 != key && n < 4000) begin step(); n++; end
        if (p2 != key) begin
            checks++; errors++;
            $display("FAIL go_to(%0d,%0d,%0d): position not reached, at key %0d", f, l, c, p2);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pix_valid"},   int'(bus.pix_valid),   0);
        chk({tag, ".sx"},          int'(bus.sx),          0);
        chk({tag, ".sy"},          int'(bus.sy),          0);
        chk({tag, ".frame_start"}, int'(bus.frame_start), 0);
        chk({tag, ".h_total"},     int'(bus.h_total),     0);
        chk({tag, ".v_total"},     int'(bus.v_total),     0);
        chk({tag, ".locked"},      int'(bus.locked),      0);
        chk({tag, ".err"},         int'(bus.err),         0);
    endtask

    initial begin
        //           f  l   c  v  sx  sy lk fs
        vecs[0]  = '{0, 0,  0, 1,  0, 0, 0, 0};
        vecs[1]  = '{0, 7,  0, 0, 15, 5, 0, 1};
        vecs[2]  = '{1, 7,  0, 0, 15, 5, 0, 1};
        vecs[3]  = '{2, 6, 23, 0, 15, 5, 0, 0};
        vecs[4]  = '{2, 7,  0, 0, 15, 5, 1, 1};
        vecs[5]  = '{3, 0,  0, 1,  0, 0, 1, 0};
        vecs[6]  = '{3, 0, 15, 1, 15, 0, 1, 0};
        vecs[7]  = '{3, 0, 16, 0, 15, 0, 1, 0};
        vecs[8]  = '{3, 2,  7, 1,  7, 2, 1, 0};
        vecs[9]  = '{3, 5, 15, 1, 15, 5, 1, 0};
        vecs[10] = '{3, 6,  3, 0, 15, 5, 1, 0};
        vecs[11] = '{3, 7,  1, 0, 15, 5, 1, 0};

        rst = 1'b1; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.de = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1 rst = 1'b0;
        chk_all_zero("reset");

        // Clean stream: pixel coordinates, frame_start and lock acquisition.
        for (int i = 0; i < 12; i++) begin
            string tag;
            go_to(vecs[i].f, vecs[i].l, vecs[i].c);
            tag = $sformatf("pix(%0d,%0d,%0d)", vecs[i].f, vecs[i].l, vecs[i].c);
            chk({tag, ".pix_valid"},   int'(bus.pix_valid),   vecs[i].v);
            chk({tag, ".sx"},          int'(bus.sx),          vecs[i].sx);
            chk({tag, ".sy"},          int'(bus.sy),          vecs[i].sy);
            chk({tag, ".locked"},      int'(bus.locked),      vecs[i].lk);
            chk({tag, ".frame_start"}, int'(bus.frame_start), vecs[i].fs);
        end
        chk("clean.h_total", int'(bus.h_total), HT);
        chk("clean.v_total", int'(bus.v_total), VT);
        chk("clean.err_cnt", err_cnt, 0);

        // One short line while locked: lock lost at next frame boundary, regained two frames later.
        short_f = 4; short_l = 2;
        go_to(4, 3, 19); chk("short.h_total", int'(bus.h_total), HT - 1);
        go_to(4, 4, 19); chk("short.h_total_back", int'(bus.h_total), HT);
        go_to(4, 6, 0);  chk("short.locked_before", int'(bus.locked), 1);
                         chk("short.err_cnt_before", err_cnt, 0);
        go_to(4, 7, 0);  chk("short.locked_lost", int'(bus.locked), 0);
                         chk("short.err_pulse", int'(bus.err), 1);
        go_to(4, 7, 1);  chk("short.err_low", int'(bus.err), 0);
                         chk("short.err_cnt", err_cnt, 1);
        go_to(5, 7, 0);  chk("short.relock_early", int'(bus.locked), 0);
        go_to(6, 7, 0);  chk("short.relock", int'(bus.locked), 1);

        // hsync stuck high while locked: timeout drops lock with a single err pulse.
        hold_f = 7;
        go_to(7, 1, 0);  chk("hold_lk.locked_before", int'(bus.locked), 1);
        go_to(7, 4, 0);  chk("hold_lk.locked", int'(bus.locked), 0);
                         chk("hold_lk.err_cnt", err_cnt, 2);

        // hsync stuck high while checking: no err pulse.
        hold_f = 8;
        go_to(8, 4, 0);  chk("hold_chk.locked", int'(bus.locked), 0);
                         chk("hold_chk.err_cnt", err_cnt, 2);

        // One over-wide active line while checking delays lock by one frame.
        wide_f = 9; wide_l = 2;
        go_to(9, 2, 16); chk("wide.pix_valid", int'(bus.pix_valid), 1);
                         chk("wide.sx", int'(bus.sx), 16);
                         chk("wide.sy", int'(bus.sy), 2);
        go_to(9, 2, 17); chk("wide.pix_valid_end", int'(bus.pix_valid), 0);
        go_to(10, 7, 0); chk("wide.locked_delayed", int'(bus.locked), 0);
        go_to(11, 7, 0); chk("wide.locked", int'(bus.locked), 1);
                         chk("wide.err_cnt", err_cnt, 2);

        // Asynchronous reset mid-line while locked.
        go_to(12, 2, 5); chk("arst.locked_before", int'(bus.locked), 1);
                         chk("arst.sx_before", int'(bus.sx), 5);
        #2 rst = 1'b1;
        #1 chk_all_zero("arst");
        repeat (2) @(posedge clk_pix);
        #1 rst = 1'b0;
        go_to(12, 7, 0); chk("arst.locked_vs", int'(bus.locked), 0);
        go_to(13, 7, 0); chk("arst.locked_one", int'(bus.locked), 0);
        go_to(14, 7, 0); chk("arst.locked_two", int'(bus.locked), 1);
        go_to(14, 8, 19);
        chk("arst.h_total", int'(bus.h_total), HT);
        chk("arst.v_total", int'(bus.v_total), VT);
        chk("arst.err_cnt", err_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
